// File: rtl/state_arbiter.sv
// rtl/state_arbiter.sv - round-robin arbiter granting one of four requesters ownership of the shared state machines
// Optional hold-limit timeout: define ARB_TIMEOUT_EN to enable the hold counter and timeout pulse.
module state_arbiter #(
  parameter int HOLD_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [3:0] state_inputs,
  output logic [1:0] grant_id,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t     state;
  logic [1:0] ptr;
  logic [1:0] pick_id;
  logic       owner_req;

  // Elaboration-time guard on the hold length range
  if (HOLD_CYCLES < 2 || HOLD_CYCLES > 255) begin : g_hold_range
    $error("state_arbiter: HOLD_CYCLES must be in 2..255");
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LIMIT = 8'(HOLD_CYCLES - 1);
  logic [7:0] hold;
`else
  assign timeout = 1'b0;
`endif

  // Round-robin pick: scan upward from ptr; the lowest offset with a request wins
  always_comb begin
    pick_id = ptr;
    for (int k = 3; k >= 0; k--) begin
      if (req[ptr + 2'(k)]) begin
        pick_id = ptr + 2'(k);
      end
    end
  end

  assign owner_req    = req[grant_id];
  assign state_inputs = grant;

  // Arbiter FSM with registered grant, owner index, busy and timeout
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      ptr      <= 2'd0;
      grant    <= 4'd0;
      grant_id <= 2'd0;
      busy     <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold     <= 8'd0;
      timeout  <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      timeout <= 1'b0;
`endif
      case (state)
        IDLE, RELEASE: begin
          if (|req) begin
            state    <= GRANT;
            grant    <= 4'b0001 << pick_id;
            grant_id <= pick_id;
            busy     <= 1'b1;
            ptr      <= pick_id + 2'd1;
`ifdef ARB_TIMEOUT_EN
            hold     <= 8'd0;
`endif
          end else begin
            state <= IDLE;
            grant <= 4'd0;
            busy  <= 1'b0;
          end
        end
        GRANT: begin
          // A voluntary release wins over a simultaneous hold-limit expiry
          if (!owner_req) begin
            state <= RELEASE;
            grant <= 4'd0;
            busy  <= 1'b0;
          end
`ifdef ARB_TIMEOUT_EN
          else if (hold == HOLD_LIMIT) begin
            state   <= RELEASE;
            grant   <= 4'd0;
            busy    <= 1'b0;
            timeout <= 1'b1;
          end else begin
            hold <= hold + 8'd1;
          end
`endif
        end
        default: begin
          state <= IDLE;
          grant <= 4'd0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_state_arbiter.sv
// tb/tb_state_arbiter.sv - directed table-driven bench for state_arbiter
module tb_state_arbiter;

  logic       clk;
  logic       reset_n;
  logic [3:0] req;
  logic [3:0] grant;
  logic [3:0] state_inputs;
  logic [1:0] grant_id;
  logic       busy;
  logic       timeout;

  int errors;
  int checks;

  state_arbiter #(.HOLD_CYCLES(8)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req          (req),
    .grant        (grant),
    .state_inputs (state_inputs),
    .grant_id     (grant_id),
    .busy         (busy),
    .timeout      (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] id;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic [3:0] eg, input logic [1:0] eid,
                         input logic eto);
    chk({name, ".grant"}, 8'(grant), 8'(eg));
    chk({name, ".state_inputs"}, 8'(state_inputs), 8'(eg));
    chk({name, ".busy"}, 8'(busy), 8'(|eg));
    chk({name, ".timeout"}, 8'(timeout), 8'(eto));
    if (eg != 4'd0) chk({name, ".grant_id"}, 8'(grant_id), 8'(eid));
    chk({name, ".onehot"}, 8'($countones(grant) <= 1), 8'd1);
  endtask

  task automatic step(input logic [3:0] r);
    req = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] r);
    req     = r;
    reset_n = 1'b0;
    #100;
    chk_out("reset", 4'd0, 2'd0, 1'b0);
    reset_n = 1'b1;
  endtask

  logic [3:0] rr_seq [5];

  initial begin
    errors  = 0;
    checks  = 0;
    reset_n = 1'b0;
    req     = 4'd0;

    tbl[0]  = '{4'h0, 4'h0, 2'd0};
    tbl[1]  = '{4'h4, 4'h4, 2'd2};
    tbl[2]  = '{4'h4, 4'h4, 2'd2};
    tbl[3]  = '{4'h0, 4'h0, 2'd0};
    tbl[4]  = '{4'h0, 4'h0, 2'd0};
    tbl[5]  = '{4'h3, 4'h1, 2'd0};
    tbl[6]  = '{4'hB, 4'h1, 2'd0};
    tbl[7]  = '{4'hE, 4'h0, 2'd0};
    tbl[8]  = '{4'hE, 4'h2, 2'd1};
    tbl[9]  = '{4'hC, 4'h0, 2'd0};
    tbl[10] = '{4'hC, 4'h4, 2'd2};
    tbl[11] = '{4'h8, 4'h0, 2'd0};
    tbl[12] = '{4'h9, 4'h8, 2'd3};
    tbl[13] = '{4'h1, 4'h0, 2'd0};
    tbl[14] = '{4'h1, 4'h1, 2'd0};
    tbl[15] = '{4'h0, 4'h0, 2'd0};
    tbl[16] = '{4'h0, 4'h0, 2'd0};

    rr_seq[0] = 4'h1;
    rr_seq[1] = 4'h2;
    rr_seq[2] = 4'h4;
    rr_seq[3] = 4'h8;
    rr_seq[4] = 4'h1;

    // Reset with all requests pending, then round-robin with 3-cycle grants
    do_reset(4'hF);
    for (int i = 0; i < 5; i++) begin
      for (int c = 0; c < 3; c++) begin
        step(4'hF);
        chk_out($sformatf("rr%0d_c%0d", i, c), rr_seq[i], 2'($clog2(rr_seq[i])), 1'b0);
      end
      step(4'hF & ~rr_seq[i]);
      chk_out($sformatf("rr%0d_dead", i), 4'h0, 2'd0, 1'b0);
    end
    step(4'h0);
    chk_out("rr_idle", 4'h0, 2'd0, 1'b0);

    // Table-driven vectors from a fresh reset
    do_reset(4'h0);
    for (int i = 0; i < 17; i++) begin
      step(tbl[i].req);
      chk_out($sformatf("vec%0d", i), tbl[i].grant, tbl[i].id, 1'b0);
    end

    // Mid-grant asynchronous reset
    do_reset(4'h0);
    step(4'h8);
    chk_out("mid_pre", 4'h8, 2'd3, 1'b0);
    step(4'h8);
    #2;
    reset_n = 1'b0;
    #1;
    chk_out("mid_async", 4'h0, 2'd0, 1'b0);
    req = 4'hF;
    #1;
    reset_n = 1'b1;
    step(4'hF);
    chk_out("mid_regrant", 4'h1, 2'd0, 1'b0);

`ifdef ARB_TIMEOUT_EN
    // Hold-limit timeout and fairness after revocation
    do_reset(4'h0);
    for (int c = 0; c < 8; c++) begin
      step(4'h3);
      chk_out($sformatf("to_a%0d", c), 4'h1, 2'd0, 1'b0);
    end
    step(4'h3);
    chk_out("to_a_pulse", 4'h0, 2'd0, 1'b1);
    for (int c = 0; c < 8; c++) begin
      step(4'h3);
      chk_out($sformatf("to_b%0d", c), 4'h2, 2'd1, 1'b0);
    end
    step(4'h3);
    chk_out("to_b_pulse", 4'h0, 2'd0, 1'b1);
    step(4'h3);
    chk_out("to_regrant", 4'h1, 2'd0, 1'b0);

    // Release on the hold-limit edge suppresses timeout
    do_reset(4'h0);
    for (int c = 0; c < 8; c++) begin
      step(4'h1);
      chk_out($sformatf("prec%0d", c), 4'h1, 2'd0, 1'b0);
    end
    step(4'h0);
    chk_out("prec_release", 4'h0, 2'd0, 1'b0);
`else
    // Without the hold limit a grant persists while requested
    do_reset(4'h0);
    for (int c = 0; c < 50; c++) begin
      step(4'h1);
      chk_out($sformatf("hold%0d", c), 4'h1, 2'd0, 1'b0);
    end
    step(4'h0);
    chk_out("hold_release", 4'h0, 2'd0, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/state_arbiter.md
STATE_ARBITER -- requirements
Module: state_arbiter

Interface
REQ-001 Parameter HOLD_CYCLES, default 8, SHALL set the maximum grant length in cycles; legal range 2..255.
REQ-002 Port clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 Port reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 Port req  input  4  SHALL carry one request per requester; bit i high means requester i wants the state machine.
REQ-005 Port grant  output  4  SHALL be a registered one-hot grant, or all zero.
REQ-006 Port state_inputs  output  4  SHALL drive the shared state_machines block and SHALL equal grant every cycle.
REQ-007 Port grant_id  output  2  SHALL give the index of the current owner; it is valid only while busy is high.
REQ-008 Port busy  output  1  SHALL be high exactly when grant is nonzero.
REQ-009 Port timeout  output  1  SHALL pulse high for one cycle when a grant is revoked by the hold limit.

Function
REQ-010 The FSM SHALL have three states: IDLE, GRANT and RELEASE, encoded in 2 bits.
REQ-011 In IDLE with req equal to 0, the FSM SHALL stay in IDLE with grant equal to 0.
REQ-012 In IDLE with any req bit set, the FSM SHALL move to GRANT; grant SHALL assert on the next rising edge (1-cycle latency).
REQ-013 Selection SHALL be round-robin: search starts at pointer ptr and moves upward modulo 4; the first set req bit wins.
REQ-014 On entry to GRANT with owner i, ptr SHALL be set to (i+1) mod 4.
REQ-015 In GRANT, a 8-bit hold counter SHALL clear on entry and increment once per cycle.
REQ-016 In GRANT, if req[owner] is low on a clock edge, the FSM SHALL move to RELEASE.
REQ-017 In GRANT, if the hold limit is reached (REQ-025), the FSM SHALL move to RELEASE even if req[owner] is still high.
REQ-018 If release (REQ-016) and the hold limit occur on the same edge, the release SHALL take precedence and timeout SHALL stay low.
REQ-019 RELEASE SHALL last exactly one cycle with grant equal to 0; this is the dead cycle between owners.
REQ-020 In RELEASE, the FSM SHALL arbitrate as in REQ-013: if any req bit is set it SHALL move to GRANT, otherwise to IDLE.
REQ-021 A requester revoked by timeout that still requests SHALL be regranted only after every other active requester has been served once.
REQ-022 Changes on non-owner req bits during GRANT SHALL have no effect on grant.
REQ-023 grant SHALL never have more than one bit set.

Reset
REQ-024 When reset_n goes low, the block SHALL immediately set: FSM to IDLE, ptr to 0, hold counter to 0, grant, state_inputs, grant_id, busy and timeout all to 0. This SHALL also apply mid-grant. The first arbitration after reset_n goes high SHALL start from requester 0.

Configuration
REQ-025 With ARB_TIMEOUT_EN defined, the hold limit SHALL be reached when the hold counter equals HOLD_CYCLES-1. Grant length SHALL therefore be at most HOLD_CYCLES cycles, and a timeout pulse SHALL coincide with the cycle in RELEASE.
REQ-026 Without ARB_TIMEOUT_EN, the hold counter and timeout logic SHALL be omitted and timeout SHALL be tied to 0. A grant SHALL then end only by REQ-016.

Verification
REQ-027 Reset: reset_n=0 for 100 ns with req=4'hF -> grant=0, busy=0, timeout=0; after release, the first grant is 4'h1.
REQ-028 Single request: req=4'h4 from IDLE -> one edge later grant=4'h4, grant_id=2, state_inputs=4'h4. Dropping req gives 1 cycle at 0, then IDLE.
REQ-029 Round-robin: req=4'hF held with each owner dropping its req after 3 cycles -> grant sequence 1,2,4,8,1 with 1 zero cycle between each.
REQ-030 Timeout (ARB_TIMEOUT_EN, HOLD_CYCLES=8): req=4'h3 held continuously -> grant=4'h1 for 8 cycles, timeout pulse, 1 zero cycle, then grant=4'h2 for 8 cycles.
REQ-031 No timeout (macro undefined): req=4'h1 held for 50 cycles -> grant=4'h1 for all 50 cycles, timeout=0 throughout.
REQ-032 Mid-grant reset: reset_n pulsed low while grant=4'h8 -> grant drops to 0 asynchronously; with req=4'hF the next grant is 4'h1.
